apb_master: RTL and testbench

APB requester that drives the APB RAM slave. Accepts 16-bit read/write requests from the system side into a small command FIFO and converts each one into a compliant APB SETUP/ACCESS transfer on `psel`/`penable`. Returns one response per request, carrying read data or an error flag. Sits directly upstream of the RAM slave and owns `paddr`, `pwrite`, `pwdata`, `psel` and `penable`.

---
 rtl/apb_master.sv | 194 +++++++++++++++++++
 tb/tb_apb_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : FIFO-fronted APB requester; APB_MASTER_TIMEOUT_EN adds ACCESS abort
// Revision : 1.0
// ============================================================================
module apb_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] paddr,
  output logic        pwrite,
  output logic [15:0] pwdata,
  output logic        psel,
  output logic        penable,
  input  logic [15:0] prdata,
  input  logic        pready
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   paddr_q, paddr_d, pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic          pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic          empty, full, push, pop, timeout_hit;
  logic [32:0]   head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign req_ready = !full && !preset;
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts consecutive stalled ACCESS cycles; fires on the one that reaches the limit.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    timeout_hit = 1'b0;
    if (state_q == S_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_ACCESS && !pready) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (!empty) begin
          pop      = 1'b1;
          state_d  = S_SETUP;
          psel_d   = 1'b1;
          pwrite_d = head[32];
          paddr_d  = head[31:16];
          pwdata_d = head[15:0];
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 16'h0000 : prdata;
          rsp_err_d   = 1'b0;
          penable_d   = 1'b0;
          if (!empty) begin
            // Chain straight into the next SETUP so psel never drops.
            pop      = 1'b1;
            state_d  = S_SETUP;
            pwrite_d = head[32];
            paddr_d  = head[31:16];
            pwdata_d = head[15:0];
          end else begin
            state_d = S_IDLE;
            psel_d  = 1'b0;
          end
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 16'h0000;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q] <= {req_write, req_addr, req_wdata};
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      paddr_q     <= 16'h0000;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 16'h0000;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : randomized bench for apb_master with RAM slave and response model
// Revision : 1.0
// ============================================================================
module tb_apb_master;
  localparam int DEPTH = 4;
  localparam int TMO   = 4;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata, paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready;

  apb_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // RAM slave: per-transfer wait count chosen in SETUP, optional stuck transfer.
  logic [15:0] ram [256];
  int wait_tgt, wait_cnt;
  int slave_waits = 0;
  bit rand_waits  = 1'b0;
  bit stuck_xfer;
  int stuck_req   = 0;
  int stuck_taken = 0;

  always @(posedge pclk) begin
    if (preset) begin
      wait_cnt   <= 0;
      wait_tgt   <= 0;
      stuck_xfer <= 1'b0;
      for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
    end else if (psel && !penable) begin
      wait_cnt   <= 0;
      wait_tgt   <= rand_waits ? int'($urandom_range(0, 3)) : slave_waits;
      stuck_xfer <= (stuck_taken < stuck_req);
      if (stuck_taken < stuck_req) stuck_taken <= stuck_taken + 1;
    end else if (psel && penable) begin
      if (pready) begin
        if (pwrite) ram[paddr[7:0]] <= pwdata;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  assign pready = psel && penable && !stuck_xfer && (wait_cnt >= wait_tgt);
  assign prdata = ram[paddr[7:0]];

  // Reference model: each accepted request predicts its response in order.
  typedef struct { logic [15:0] rdata; logic err; } exp_t;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [15:0] ref_mem [256];
  int          abort_req  = 0;
  int          abort_used = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr, prev_wdata;
  logic        prev_write;

  always @(negedge pclk) begin
    if (preset) begin
      exp_q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
      prev_wait = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        mon_e.err   = 1'b0;
        mon_e.rdata = 16'h0000;
        if (abort_used < abort_req) begin
          mon_e.err = 1'b1;
          abort_used++;
        end else if (req_write) begin
          ref_mem[req_addr[7:0]] = req_wdata;
        end else begin
          mon_e.rdata = ref_mem[req_addr[7:0]];
        end
        exp_q.push_back(mon_e);
      end
      if (rsp_valid) begin
        check("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", rsp_err, mon_e.err);
        end
      end
      check("enable_without_sel", penable && !psel, 0);
      if (prev_wait && psel) begin
        check("hold_paddr", paddr, prev_addr);
        check("hold_pwdata", pwdata, prev_wdata);
        check("hold_pwrite", pwrite, prev_write);
        check("hold_penable", penable, 1);
      end
      prev_wait  = psel && penable && !pready;
      prev_addr  = paddr;
      prev_wdata = pwdata;
      prev_write = pwrite;
    end
  end

  task automatic push(input bit w, input logic [15:0] a, input logic [15:0] d, output int acc);
    int n;
    @(posedge pclk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    @(negedge pclk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge pclk);
    end
    check("push_accept", req_ready, 1);
    acc = cyc;
  endtask

  task automatic drop();
    @(posedge pclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int t);
    for (int c = 0; c < 300; c++) begin
      @(negedge pclk);
      if (rsp_valid) break;
    end
    check("rsp_wait", rsp_valid, 1);
    t = cyc;
  endtask

  task automatic wait_access();
    for (int c = 0; c < 100; c++) begin
      @(negedge pclk);
      if (psel && penable) break;
    end
    check("reach_access", psel && penable, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk);
      if (!busy && !rsp_valid && exp_q.size() == 0) break;
    end
    check("drain_busy", busy, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  task automatic single(input bit w, input logic [15:0] a, input logic [15:0] d, input int waits);
    int k, t;
    drain();
    slave_waits = waits;
    push(w, a, d, k);
    drop();
    wait_rsp(t);
    check("latency", t - k - 1, 3 + waits);
  endtask

  int k0, k1, t0;

  initial begin
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_req_ready", req_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_psel", psel, 0);
    check("post_rst_busy", busy, 0);

    // Write then read back, zero-wait and two-wait.
    single(1'b1, 16'h0010, 16'h1234, 0);
    single(1'b0, 16'h0010, 16'h0000, 0);
    single(1'b1, 16'h0020, 16'hBEEF, 2);
    single(1'b0, 16'h0020, 16'h0000, 2);

    // Long first transfer lets the FIFO fill behind it.
    drain();
    slave_waits = 10;
    push(1'b0, 16'h0010, 16'h0000, k0);
    drop();
    wait_access();
    slave_waits = 0;
    fork
      begin : pusher
        int kk;
        for (int i = 0; i < 4; i++) push(i[0], 16'h0040 + 16'(i), 16'hA000 + 16'(i), kk);
        @(posedge pclk); #1;
        req_write = 1'b0; req_addr = 16'h0041; req_wdata = 16'h0000;
        @(negedge pclk);
        check("full_ready", req_ready, 0);
        for (int c = 0; c < 100; c++) begin
          if (req_ready) break;
          @(negedge pclk);
        end
        check("push5_accept", req_ready, 1);
        drop();
      end
      begin : observer
        int tt [6];
        int n;
        n = 0;
        for (int c = 0; c < 300 && n < 6; c++) begin
          @(negedge pclk);
          if (rsp_valid) begin
            tt[n] = cyc;
            n++;
          end
          if (n < 6) check("b2b_psel", psel, 1);
        end
        check("b2b_count", n, 6);
        for (int i = 1; i < 6; i++) check("b2b_gap", tt[i] - tt[i-1], 2);
      end
    join

    // Reset during ACCESS with two reads queued behind it.
    drain();
    slave_waits = 20;
    push(1'b0, 16'h0010, 16'h0000, k0);
    push(1'b0, 16'h0020, 16'h0000, k0);
    push(1'b0, 16'h0041, 16'h0000, k0);
    drop();
    wait_access();
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    slave_waits = 0;
    @(negedge pclk);
    check("midrst_psel", psel, 0);
    check("midrst_penable", penable, 0);
    check("midrst_busy", busy, 0);
    for (int c = 0; c < 10; c++) begin
      check("midrst_no_rsp", rsp_valid, 0);
      @(negedge pclk);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave: the write aborts, the queued read still completes.
    single(1'b1, 16'h0011, 16'h7777, 0);
    drain();
    abort_req++;
    stuck_req++;
    push(1'b1, 16'h0011, 16'hDEAD, k0);
    push(1'b0, 16'h0011, 16'h0000, k1);
    drop();
    wait_rsp(t0);
    check("tmo_latency", t0 - k0 - 1, 2 + TMO);
    check("tmo_psel", psel, 0);
    check("tmo_err", rsp_err, 1);
    check("tmo_rdata", rsp_rdata, 0);
    wait_rsp(t0);
    check("tmo_next_err", rsp_err, 0);
    check("tmo_next_rdata", rsp_rdata, 16'h7777);
`endif

    // Randomized traffic with random slave waits.
    drain();
    rand_waits = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom), k0);
      if ($urandom_range(0, 2) == 0) drop();
    end
    drop();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
